// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants and types for engines around the 32x16K dual-port RAM
package dpram_pkg;

    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    typedef logic [RAM_ADDR_W:0] rd_len_t;

endpackage

// File: rtl/sync_fifo_small.sv
// rtl/sync_fifo_small.sv - small register FIFO with combinational head, power-of-two depth
module sync_fifo_small #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign count    = cnt_q;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// rtl/dpram_stream_reader.sv - drains an address window of the dual-port RAM through port B
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   pop_cnt;
    logic              inflight_q;
    logic              done_q;
    logic              done_d;
    logic              accept;
    logic              issue;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  credit_limit;

    // A start coinciding with done is dropped: the previous command is still finishing.
    assign accept       = start && (state_q == IDLE) && !done_q;
    assign pop          = m_valid && m_ready;
    // Credits count FIFO entries plus the read in flight; a same-cycle pop frees one slot.
    assign occupancy    = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign credit_limit = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
    assign issue        = (state_q == READ) && (issue_cnt != '0) &&
                          (occupancy < credit_limit) && (!fifo_full || pop);

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ram_addr = issue ? addr_q : last_addr_q;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign m_valid  = !fifo_empty;
    assign m_last   = m_valid && (pop_cnt == ONE);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (len == '0)) begin
                    done_d = 1'b1;
                end else if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (issue && (issue_cnt == ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (pop_cnt == ONE)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            addr_q      <= '0;
            last_addr_q <= '0;
            issue_cnt   <= '0;
            pop_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (accept && (len != '0)) begin
                addr_q    <= base_addr;
                issue_cnt <= len;
                pop_cnt   <= len;
            end else begin
                if (issue) begin
                    addr_q      <= addr_q + 1'b1;
                    last_addr_q <= addr_q;
                    issue_cnt   <= issue_cnt - 1'b1;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt - 1'b1;
                end
            end
        end
    end

    sync_fifo_small #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (ram_dout),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb/tb_dpram_stream_reader.sv - bench for dpram_stream_reader with a behavioural RAM
module tb_dpram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    logic        we_a;
    logic [13:0] addr_a;
    logic [31:0] din_a;

    logic [31:0] ram     [16384];
    logic [31:0] ref_mem [16384];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we_a) ram[addr_a] <= din_a;
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    dpram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    typedef struct {
        int base;
        int ln;
        bit rnd;
        int inj;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic write_a(input int a, input logic [31:0] d);
        we_a   = 1'b1;
        addr_a = a[13:0];
        din_a  = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        we_a = 1'b0;
    endtask

    task automatic run_cmd(input int base, input int ln, input bit rnd, input int inj,
                           input int exp_first, input int exp_done, input string tag);
        logic [31:0] gd[$];
        bit          gl[$];
        int          gc[$];
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          extra = 0;
        int          bad_stable = 0;
        int          bad_we = 0;
        int          bad_occ = 0;
        int          bad_idle = 0;
        logic        busy_at_done = 1'b1;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic [13:0] addr_seq [1:3];
        int          nw;
        start     = 1'b1;
        base_addr = base[13:0];
        len       = ln[14:0];
        m_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; (k <= 20 + 8 * ln) && (extra < 6); k++) begin
            @(negedge clk);
            if (k <= 3) addr_seq[k] = ram_addr;
            if (prev_stall && (!m_valid || m_data !== prev_data)) bad_stable++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (ram_we !== 1'b0 || ram_din !== 32'h0) bad_we++;
            if (dut.u_fifo.count > 2) bad_occ++;
            if (busy || m_valid) bad_idle++;
            if (m_valid && m_ready) begin
                gd.push_back(m_data);
                gl.push_back(m_last);
                gc.push_back(k);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = k;
                    busy_at_done = busy;
                end
            end
            if (done_cnt > 0) extra++;
            @(posedge clk);
            #1;
            start = (k + 1 == inj);
            if (start) begin
                base_addr = '0;
                len       = 15'd4;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start = 1'b0;
        nw = gd.size();
        chk({tag, ".words"}, nw, ln);
        for (int i = 0; i < nw && i < ln; i++) begin
            chk($sformatf("%s.data%0d", tag, i), int'(gd[i]), int'(ref_mem[(base + i) % 16384]));
            chk($sformatf("%s.last%0d", tag, i), int'(gl[i]), int'(i == ln - 1));
        end
        chk({tag, ".done_count"}, done_cnt, 1);
        chk({tag, ".busy_at_done"}, int'(busy_at_done), 0);
        chk({tag, ".busy_end"}, int'(busy), 0);
        chk({tag, ".stable"}, bad_stable, 0);
        chk({tag, ".ram_we"}, bad_we, 0);
        chk({tag, ".fifo_occ"}, bad_occ, 0);
        if (ln == 0) chk({tag, ".idle_len0"}, bad_idle, 0);
        if (exp_first >= 0 && nw > 0) begin
            chk({tag, ".first_cycle"}, gc[0], exp_first);
            chk({tag, ".back_to_back"}, gc[nw - 1] - gc[0], nw - 1);
        end
        if (exp_done >= 0) chk({tag, ".done_cycle"}, done_cyc, exp_done);
        if (!rnd && ln >= 3) begin
            for (int k = 1; k <= 3; k++) begin
                chk($sformatf("%s.ram_addr%0d", tag, k), int'(addr_seq[k]), (base + k - 1) % 16384);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        we_a = 1'b0; addr_a = '0; din_a = '0;

        vecs[0] = '{100,   4,  1'b0, 0, 3, 7};
        vecs[1] = '{16382, 3,  1'b0, 0, 3, 6};
        vecs[2] = '{500,   8,  1'b1, 0, -1, -1};
        vecs[3] = '{123,   0,  1'b0, 0, -1, 1};
        vecs[4] = '{2000,  16, 1'b0, 5, 3, 19};
        vecs[5] = '{200,   2,  1'b0, 5, 3, 5};
        vecs[6] = '{16380, 20, 1'b1, 0, -1, -1};
        vecs[7] = '{9000,  1,  1'b0, 0, 3, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.m_valid", int'(m_valid), 0);
        chk("rst.m_last", int'(m_last), 0);
        chk("rst.m_data", int'(m_data), 0);
        chk("rst.ram_addr", int'(ram_addr), 0);

        for (int a = 0; a < 16384; a++) write_a(a, $urandom);
        for (int a = 0; a < 4; a++) write_a(100 + a, 32'hA0 + 32'(a));
        write_a(16382, 32'h11);
        write_a(16383, 32'h22);
        write_a(0, 32'h33);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].base, vecs[i].ln, vecs[i].rnd, vecs[i].inj,
                    vecs[i].exp_first, vecs[i].exp_done, $sformatf("vec%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end

        for (int r = 0; r < 6; r++) begin
            run_cmd(int'($urandom_range(0, 16383)), int'($urandom_range(1, 40)), 1'b1, 0,
                    -1, -1, $sformatf("rnd%0d", r));
            @(posedge clk);
            #1;
        end

        start = 1'b1; base_addr = 14'd300; len = 15'd10; m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.pre_valid", int'(m_valid), 1);
        chk("midrst.pre_data", int'(m_data), int'(ref_mem[302]));
        rst_n = 1'b0;
        #1;
        chk("midrst.m_valid", int'(m_valid), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.m_last", int'(m_last), 0);
        chk("midrst.ram_addr", int'(ram_addr), 0);
        @(posedge clk);
        #1;
        chk("midrst.done_hold", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.done_after", int'(done), 0);
        run_cmd(700, 2, 1'b0, 0, 3, 5, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
